// File: rtl/sd_spi_engine.sv
// SD-card SPI-mode master PHY: mode-0 SCK from a programmable divider, byte
// shifting under valid/ready, MISO synchroniser, multi-card chip select and a
// hardware init sequence (CS high, INIT_CLKS clocks).
// Optional macro SD_SPI_CRC7_EN: running CRC7 over transmitted bits on crc7.
module sd_spi_engine #(
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CS_COUNT    = 1,
  parameter int INIT_CLKS   = 80,
  localparam int CS_W       = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [CS_W-1:0]     cs_sel,
  input  logic                init_req,
  output logic                init_done,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [7:0]          tx_data,
  input  logic                tx_last,
  output logic                rx_valid,
  output logic [7:0]          rx_data,
  output logic                busy,
  output logic [6:0]          crc7,
  output logic                sd_sck,
  output logic                sd_mosi,
  input  logic                sd_miso,
  output logic [CS_COUNT-1:0] sd_cs_n
);

  localparam int SYNC_W = $clog2(SYNC_STAGES + 1);
  localparam int CNT_W  = (DIV_W > SYNC_W) ? DIV_W : SYNC_W;
  localparam int PCNT_W = $clog2(INIT_CLKS);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_HOLD, S_END, S_INIT} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, hlim_reg, hlim_next, div_ext, hlim_new;
  logic                high_reg, high_next;
  logic [2:0]          bit_reg, bit_next;
  logic [PCNT_W-1:0]   pcnt_reg, pcnt_next;
  logic [6:0]          tx_sh_reg, tx_sh_next, rx_sh_reg, rx_sh_next;
  logic [7:0]          rx_data_reg, rx_data_next;
  logic                last_reg, last_next;
  logic [CS_W-1:0]     cs_idx_reg, cs_idx_next;
  logic                sck_reg, sck_next, mosi_reg, mosi_next;
  logic [CS_COUNT-1:0] cs_n_reg, cs_n_next, cs_hit;
  logic                rx_valid_reg, rx_valid_next, init_done_reg, init_done_next;
  logic                cs_on, cnt_end, miso_s;
  logic [SYNC_STAGES-1:0] sync_reg;
`ifdef SD_SPI_CRC7_EN
  logic [6:0]          crc_reg, crc_next, crc_step;
  logic                crc_fb;
`endif

  // H-1 = max(cfg_div, SYNC_STAGES): the half period never undercuts the synchroniser delay
  assign div_ext  = CNT_W'(cfg_div);
  assign hlim_new = (div_ext > CNT_W'(SYNC_STAGES)) ? div_ext : CNT_W'(SYNC_STAGES);
  assign cnt_end  = (cnt_reg == hlim_reg);
  assign miso_s   = sync_reg[SYNC_STAGES-1];

`ifdef SD_SPI_CRC7_EN
  // x^7 + x^3 + 1 over the bit currently on MOSI
  assign crc_fb   = crc_reg[6] ^ mosi_reg;
  assign crc_step = {crc_reg[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
  assign crc7     = crc_reg;
`else
  assign crc7     = 7'd0;
`endif

  // one compare per select line; an out-of-range index matches nothing
  for (genvar gi = 0; gi < CS_COUNT; gi++) begin : g_cs
    assign cs_hit[gi] = (cs_idx_next == CS_W'(gi));
  end
  assign cs_n_next = cs_on ? ~cs_hit : {CS_COUNT{1'b1}};

  assign busy      = (state_reg != S_IDLE);
  assign tx_ready  = ((state_reg == S_IDLE) && !init_req) || (state_reg == S_HOLD);
  assign sd_sck    = sck_reg;
  assign sd_mosi   = mosi_reg;
  assign sd_cs_n   = cs_n_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;
  assign init_done = init_done_reg;

  // MISO synchroniser and all state/output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg      <= '0;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      hlim_reg      <= '0;
      high_reg      <= 1'b0;
      bit_reg       <= '0;
      pcnt_reg      <= '0;
      tx_sh_reg     <= '0;
      rx_sh_reg     <= '0;
      rx_data_reg   <= '0;
      last_reg      <= 1'b0;
      cs_idx_reg    <= '0;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b1;
      cs_n_reg      <= {CS_COUNT{1'b1}};
      rx_valid_reg  <= 1'b0;
      init_done_reg <= 1'b0;
`ifdef SD_SPI_CRC7_EN
      crc_reg       <= '0;
`endif
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], sd_miso};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hlim_reg      <= hlim_next;
      high_reg      <= high_next;
      bit_reg       <= bit_next;
      pcnt_reg      <= pcnt_next;
      tx_sh_reg     <= tx_sh_next;
      rx_sh_reg     <= rx_sh_next;
      rx_data_reg   <= rx_data_next;
      last_reg      <= last_next;
      cs_idx_reg    <= cs_idx_next;
      sck_reg       <= sck_next;
      mosi_reg      <= mosi_next;
      cs_n_reg      <= cs_n_next;
      rx_valid_reg  <= rx_valid_next;
      init_done_reg <= init_done_next;
`ifdef SD_SPI_CRC7_EN
      crc_reg       <= crc_next;
`endif
    end
  end

  // next state, phase counters and next pin values (pins are registered)
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hlim_next      = hlim_reg;
    high_next      = high_reg;
    bit_next       = bit_reg;
    pcnt_next      = pcnt_reg;
    tx_sh_next     = tx_sh_reg;
    rx_sh_next     = rx_sh_reg;
    rx_data_next   = rx_data_reg;
    last_next      = last_reg;
    cs_idx_next    = cs_idx_reg;
    sck_next       = 1'b0;
    mosi_next      = 1'b1;
    cs_on          = 1'b0;
    rx_valid_next  = 1'b0;
    init_done_next = 1'b0;
`ifdef SD_SPI_CRC7_EN
    crc_next       = crc_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (init_req) begin
          state_next = S_INIT;
          hlim_next  = hlim_new;
          cnt_next   = '0;
          high_next  = 1'b0;
          pcnt_next  = '0;
        end else if (tx_valid) begin
          state_next  = S_SHIFT;
          hlim_next   = hlim_new;
          cs_idx_next = cs_sel;
          last_next   = tx_last;
          tx_sh_next  = tx_data[6:0];
          mosi_next   = tx_data[7];
          cnt_next    = '0;
          high_next   = 1'b0;
          bit_next    = '0;
          cs_on       = 1'b1;
`ifdef SD_SPI_CRC7_EN
          crc_next    = '0;
`endif
        end
      end
      S_SHIFT: begin
        cs_on     = 1'b1;
        sck_next  = high_reg;
        mosi_next = mosi_reg;
        if (!cnt_end) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          cnt_next = '0;
          if (!high_reg) begin
            high_next = 1'b1;
            sck_next  = 1'b1;
          end else begin
            // last cycle of the high phase: sample MISO, then SCK falls
            high_next  = 1'b0;
            sck_next   = 1'b0;
            rx_sh_next = {rx_sh_reg[5:0], miso_s};
`ifdef SD_SPI_CRC7_EN
            crc_next   = crc_step;
`endif
            if (bit_reg == 3'd7) begin
              rx_valid_next = 1'b1;
              rx_data_next  = {rx_sh_reg, miso_s};
              mosi_next     = 1'b1;
              state_next    = last_reg ? S_END : S_HOLD;
            end else begin
              bit_next   = bit_reg + 3'd1;
              mosi_next  = tx_sh_reg[6];
              tx_sh_next = {tx_sh_reg[5:0], 1'b0};
            end
          end
        end
      end
      S_HOLD: begin
        cs_on = 1'b1;
        if (tx_valid) begin
          state_next = S_SHIFT;
          last_next  = tx_last;
          tx_sh_next = tx_data[6:0];
          mosi_next  = tx_data[7];
          cnt_next   = '0;
          high_next  = 1'b0;
          bit_next   = '0;
        end
      end
      S_END: begin
        if (cnt_end) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          cs_on    = 1'b1;
        end
      end
      S_INIT: begin
        sck_next = high_reg;
        if (!cnt_end) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          cnt_next = '0;
          if (!high_reg) begin
            high_next = 1'b1;
            sck_next  = 1'b1;
          end else begin
            high_next = 1'b0;
            sck_next  = 1'b0;
            if (pcnt_reg == PCNT_W'(INIT_CLKS - 1)) begin
              state_next     = S_IDLE;
              init_done_next = 1'b1;
            end else begin
              pcnt_next = pcnt_reg + PCNT_W'(1);
            end
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Directed bench for sd_spi_engine with a timeline model (position k inside
// each transaction, outputs derived arithmetically) and a per-cycle compare.
module tb_sd_spi_engine;
  localparam int CSN   = 5;
  localparam int SS    = 2;
  localparam int ICLKS = 80;
`ifdef SD_SPI_CRC7_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] cfg_div = 8'd3;
  logic [2:0] cs_sel = 3'd0;
  logic init_req = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic miso_loop = 1'b1, miso_drv = 1'b0, glitch_en = 1'b0;
  logic init_done, tx_ready, rx_valid, busy, sd_sck, sd_mosi, sd_miso;
  logic [7:0] rx_data;
  logic [6:0] crc7;
  logic [CSN-1:0] sd_cs_n;

  assign sd_miso = miso_loop ? sd_mosi : miso_drv;

  sd_spi_engine #(.DIV_W(8), .SYNC_STAGES(SS), .CS_COUNT(CSN), .INIT_CLKS(ICLKS)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_div(cfg_div), .cs_sel(cs_sel),
    .init_req(init_req), .init_done(init_done), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .crc7(crc7),
    .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso), .sd_cs_n(sd_cs_n)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  // ---------------- model: mode + position k within it ----------------
  int m_mode = 0;  // 0 idle, 1 shift, 2 hold, 3 end, 4 init
  int m_k = 0, m_h = 4, m_cs = 0;
  logic [7:0] m_data = 8'h00, m_rxd = 8'h00;
  logic m_last = 1'b0, m_rxv = 1'b0, m_done = 1'b0;
  logic [6:0] m_crc = 7'h00;

  function automatic int hcalc(input logic [7:0] d);
    return (int'(d) + 1 > SS + 1) ? int'(d) + 1 : SS + 1;
  endfunction

  function automatic logic [6:0] crc_byte(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_mode = 0; m_k = 0; m_rxv = 1'b0; m_done = 1'b0; m_rxd = 8'h00; m_crc = 7'h00;
    end else begin
      m_rxv = 1'b0; m_done = 1'b0;
      case (m_mode)
        0: if (init_req) begin
             m_h = hcalc(cfg_div); m_mode = 4; m_k = 0;
           end else if (tx_valid) begin
             m_h = hcalc(cfg_div); m_data = tx_data; m_last = tx_last; m_cs = int'(cs_sel);
             m_crc = 7'h00; m_mode = 1; m_k = 0;
           end
        1: if (m_k == 16 * m_h - 1) begin
             m_rxv = 1'b1; m_rxd = miso_loop ? m_data : 8'h00;
             m_crc = crc_byte(m_crc, m_data); m_mode = m_last ? 3 : 2; m_k = 0;
           end else m_k++;
        2: if (tx_valid) begin
             m_data = tx_data; m_last = tx_last; m_mode = 1; m_k = 0;
           end
        3: if (m_k == m_h - 1) begin m_mode = 0; m_k = 0; end else m_k++;
        4: if (m_k == 2 * m_h * ICLKS - 1) begin m_mode = 0; m_done = 1'b1; m_k = 0; end
           else m_k++;
        default: m_mode = 0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic e_sck, e_mosi, e_busy, e_rdy, bad;
    logic [CSN-1:0] e_cs, sel_mask;
    logic [6:0] e_crc;
    @(negedge clk);
    sel_mask = '1;
    if (m_cs < CSN) sel_mask[m_cs] = 1'b0;
    e_sck = 1'b0; e_mosi = 1'b1; e_cs = '1;
    case (m_mode)
      1: begin e_sck = ((m_k / m_h) % 2) == 1; e_mosi = m_data[7 - m_k / (2 * m_h)]; e_cs = sel_mask; end
      2, 3: e_cs = sel_mask;
      4: e_sck = ((m_k / m_h) % 2) == 1;
      default: ;
    endcase
    e_busy = (m_mode != 0);
    e_rdy = ((m_mode == 0) && !init_req) || (m_mode == 2);
    e_crc = CRC_ON ? (m_rxv ? m_crc : crc7) : 7'h00;
    bad = (sd_sck !== e_sck) || (sd_mosi !== e_mosi) || (sd_cs_n !== e_cs) ||
          (busy !== e_busy) || (tx_ready !== e_rdy) || (rx_valid !== m_rxv) ||
          (rx_data !== m_rxd) || (init_done !== m_done) || (crc7 !== e_crc);
    tests++;
    if (bad) begin
      fails++;
      if (fails <= 40)
        $display("FAIL cycle %0d (got/want): sck %b/%b mosi %b/%b cs %b/%b busy %b/%b rdy %b/%b rxv %b/%b rxd %h/%h done %b/%b crc %h/%h",
                 cyc, sd_sck, e_sck, sd_mosi, e_mosi, sd_cs_n, e_cs, busy, e_busy, tx_ready, e_rdy,
                 rx_valid, m_rxv, rx_data, m_rxd, init_done, m_done, crc7, e_crc);
    end
  end

  // ---------------- event monitor ----------------
  int rises = 0, hi_cnt = 0, rxv_cnt = 0, last_rx = 0, last_done = 0, last_fall = 0, last_rise = 0;
  int cs_fall [CSN];
  logic p_sck = 1'b0;
  logic [CSN-1:0] p_cs = '1;
  initial begin
    for (int i = 0; i < CSN; i++) cs_fall[i] = 0;
    forever begin
      @(negedge clk);
      if (sd_sck && !p_sck) rises++;
      if (sd_sck) hi_cnt++;
      if (rx_valid) begin rxv_cnt++; last_rx = cyc; end
      if (init_done) last_done = cyc;
      for (int i = 0; i < CSN; i++) begin
        if (!sd_cs_n[i] && p_cs[i]) begin cs_fall[i]++; last_fall = cyc; end
        if (sd_cs_n[i] && !p_cs[i]) last_rise = cyc;
      end
      p_sck = sd_sck; p_cs = sd_cs_n;
    end
  end

  // one-cycle MISO glitch at position 1 of every low phase
  initial forever begin
    @(negedge clk);
    miso_drv = glitch_en && (m_mode == 1) && ((m_k % (2 * m_h)) == 1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  int hs_cyc = 0;
  task automatic send(input logic [7:0] d, input logic l, input logic [2:0] s);
    bit acc = 1'b0;
    tx_data = d; tx_last = l; cs_sel = s; tx_valid = 1'b1;
    for (int i = 0; i < 4000 && !acc; i++) begin
      if (tx_ready) acc = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    hs_cyc = cyc;
    chk("accept", int'(acc), 1);
    $display("[TB] tx 0x%02h last=%0b sel=%0d accepted at cycle %0d", d, l, s, hs_cyc - 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (m_mode == 0) ok = 1'b1;
    end
    @(negedge clk);
    chk("idle_timeout", int'(ok), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r0, h0, rx0, c0, f0, f2, f3, fsum;
    repeat (3) @(negedge clk);
    chk("rst_sck", int'(sd_sck), 0);
    chk("rst_mosi", int'(sd_mosi), 1);
    chk("rst_cs", int'(sd_cs_n), 'h1F);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rxd", int'(rx_data), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // single byte, H=4, loopback
    cfg_div = 8'd3; miso_loop = 1'b1;
    r0 = rises; h0 = hi_cnt;
    send(8'hA5, 1'b1, 3'd0);
    wait_idle();
    chk("t1_rxd", int'(rx_data), 'hA5);
    chk("t1_cs_low_T1", last_fall - hs_cyc, 0);
    chk("t1_rxv_T65", last_rx - hs_cyc, 64);
    chk("t1_cs_high_T69", last_rise - hs_cyc, 68);
    chk("t1_sck_pulses", rises - r0, 8);
    chk("t1_sck_high_cycles", hi_cnt - h0, 32);

    // init sequence with a byte offered at the same time
    cfg_div = 8'd0; c0 = cyc; r0 = rises;
    init_req = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b1; cs_sel = 3'd0;
    @(negedge clk);
    init_req = 1'b0;
    send(8'h5A, 1'b1, 3'd0);
    chk("t2_done_481", last_done - c0, 481);
    chk("t2_accept_after_init", hs_cyc - c0, 482);
    chk("t2_init_clks", rises - r0, 80);
    wait_idle();
    chk("t2_rxd", int'(rx_data), 'h5A);

    // CMD0 frame
    cfg_div = 8'd2; f0 = cs_fall[0]; rx0 = rxv_cnt;
    send(8'h40, 1'b0, 3'd0); send(8'h00, 1'b0, 3'd0); send(8'h00, 1'b0, 3'd0);
    send(8'h00, 1'b0, 3'd0); send(8'h00, 1'b1, 3'd0);
    wait_idle();
    chk("cmd0_cs_one_fall", cs_fall[0] - f0, 1);
    chk("cmd0_rxv", rxv_cnt - rx0, 5);
    chk("cmd0_crc", int'(crc7), CRC_ON ? 'h4A : 0);

    // CMD8 frame
    f0 = cs_fall[0]; rx0 = rxv_cnt;
    send(8'h48, 1'b0, 3'd0); send(8'h00, 1'b0, 3'd0); send(8'h00, 1'b0, 3'd0);
    send(8'h01, 1'b0, 3'd0); send(8'hAA, 1'b1, 3'd0);
    wait_idle();
    chk("cmd8_cs_one_fall", cs_fall[0] - f0, 1);
    chk("cmd8_rxv", rxv_cnt - rx0, 5);
    chk("cmd8_crc", int'(crc7), CRC_ON ? 'h43 : 0);
    chk("cmd8_rxd", int'(rx_data), 'hAA);

    // multi-card select: cs_sel changes in HOLD are ignored
    cfg_div = 8'd1; f0 = cs_fall[0]; f2 = cs_fall[2]; f3 = cs_fall[3];
    send(8'h11, 1'b0, 3'd2); send(8'h22, 1'b0, 3'd3); send(8'h33, 1'b1, 3'd3);
    wait_idle();
    chk("cs2_fall", cs_fall[2] - f2, 1);
    chk("cs3_quiet", cs_fall[3] - f3, 0);
    chk("cs0_quiet", cs_fall[0] - f0, 0);
    fsum = 0;
    for (int i = 0; i < CSN; i++) fsum += cs_fall[i];
    rx0 = rxv_cnt;
    send(8'h55, 1'b1, 3'd5);
    wait_idle();
    for (int i = 0; i < CSN; i++) fsum -= cs_fall[i];
    chk("cs_out_of_range_none", fsum, 0);
    chk("cs_out_of_range_rxv", rxv_cnt - rx0, 1);
    chk("cs_out_of_range_rxd", int'(rx_data), 'h55);

    // reset during bit 4
    cfg_div = 8'd3; rx0 = rxv_cnt;
    send(8'h96, 1'b1, 3'd0);
    repeat (34) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sck", int'(sd_sck), 0);
    chk("arst_mosi", int'(sd_mosi), 1);
    chk("arst_cs", int'(sd_cs_n), 'h1F);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rxd", int'(rx_data), 0);
    chk("arst_crc", int'(crc7), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_no_rxv", rxv_cnt - rx0, 0);
    send(8'hC3, 1'b1, 3'd0);
    wait_idle();
    chk("arst_next_rxd", int'(rx_data), 'hC3);

    // glitch on MISO must not reach the sampled bits
    miso_loop = 1'b0; glitch_en = 1'b1; rx0 = rxv_cnt;
    send(8'h3C, 1'b1, 3'd0);
    wait_idle();
    glitch_en = 1'b0; miso_loop = 1'b1;
    chk("glitch_rxd", int'(rx_data), 0);
    chk("glitch_rxv", rxv_cnt - rx0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
